// File: rtl/tt_sweep_pkg.sv
// Shared types and limits for the truth-table sweeper.
package tt_sweep_pkg;
  localparam int unsigned N_MAX    = 8;
  localparam int unsigned HOLD_MAX = 15;
  localparam int unsigned HOLD_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    FINISH
  } tt_state_t;
endpackage

// File: rtl/tt_hold_timer.sv
// Per-vector settle timer: reloads on each new vector, flags expiry at zero.
module tt_hold_timer
  import tt_sweep_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [HOLD_W-1:0] value,
  output logic              expire
);

  logic [HOLD_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - HOLD_W'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/tt_sweeper.sv
// Truth-table sweeper: drives every input vector, samples y_in after the
// settle time and scores it against EXPECTED. Observed-table capture is
// built only when TT_SWEEP_OBS_EN is defined.
module tt_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int unsigned      N        = 3,
  parameter logic [2**N-1:0]  EXPECTED = 8'h31,
  parameter int unsigned      HOLD     = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic [N-1:0]      vec_out,
  input  logic              y_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N:0]        err_count,
  output logic [N-1:0]      first_fail,
  output logic [2**N-1:0]   obs_table
);

  localparam logic [HOLD_W-1:0] HOLD_V = HOLD_W'(HOLD);

  tt_state_t    state, state_next;
  logic         expire;
  logic         launch, sample, advance, last_vec, mismatch;
  logic [N:0]   work_err, err_next;
  logic [N-1:0] work_first, first_next;

  assign last_vec = (vec_out == '1);
  assign mismatch = y_in ^ EXPECTED[vec_out];
  assign launch   = (state == IDLE) && start && !abort;
  assign sample   = (state == DRIVE) && expire && !abort;
  assign advance  = sample && !last_vec;

  tt_hold_timer u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (launch | advance),
    .value   (HOLD_V),
    .expire  (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (launch) state_next = DRIVE;
      DRIVE:   if (abort) state_next = IDLE;
               else if (sample && last_vec) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DRIVE);
    done = (state == FINISH);
  end

  // Final sample folds straight into the published results so they are valid in FINISH.
  always_comb begin
    err_next   = work_err + (N+1)'(mismatch);
    first_next = (mismatch && work_err == '0) ? vec_out : work_first;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vec_out    <= '0;
      work_err   <= '0;
      work_first <= '0;
      err_count  <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
    end else if (launch) begin
      vec_out    <= '0;
      work_err   <= '0;
      work_first <= '0;
    end else if (state == DRIVE && abort) begin
      vec_out <= '0;
      pass    <= 1'b0;
    end else if (sample) begin
      work_err   <= err_next;
      work_first <= first_next;
      if (last_vec) begin
        vec_out    <= '0;
        err_count  <= err_next;
        first_fail <= first_next;
        pass       <= (err_next == '0);
      end else begin
        vec_out <= vec_out + N'(1);
      end
    end
  end

`ifdef TT_SWEEP_OBS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    obs_table <= '0;
    else if (launch) obs_table <= '0;
    else if (sample) obs_table[vec_out] <= y_in;
  end
`else
  assign obs_table = '0;
`endif

endmodule

// File: tb/tb_tt_sweeper.sv
// Randomized self-checking bench for tt_sweeper against a table-level model.
module tb_tt_sweeper;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0;
  logic [2:0] vec_out;
  logic       y_in, busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] first_fail;
  logic [7:0] obs_table;
  logic [7:0] fut = 8'h00;

  logic       start0 = 1'b0;
  logic [2:0] vec_out0;
  logic       y_in0, busy0, done0, pass0;
  logic [3:0] err_count0;
  logic [2:0] first_fail0;
  logic [7:0] obs_table0;
  logic [7:0] fut0 = 8'h00;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign y_in  = fut[vec_out];
  assign y_in0 = fut0[vec_out0];

  tt_sweeper dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .vec_out(vec_out), .y_in(y_in), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail), .obs_table(obs_table)
  );

  tt_sweeper #(.N(3), .EXPECTED(8'h31), .HOLD(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .abort(1'b0),
    .vec_out(vec_out0), .y_in(y_in0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err_count0), .first_fail(first_fail0), .obs_table(obs_table0)
  );

  // Reference table built from the boolean function y = ~b&~c | a&~b, vector {a,b,c}.
  function automatic logic [7:0] ref_table();
    logic [7:0] t;
    for (int v = 0; v < 8; v++) begin
      logic a, b, c;
      a = v[2]; b = v[1]; c = v[0];
      t[v] = (~b & ~c) | (a & ~b);
    end
    return t;
  endfunction

  function automatic int model_errs(input logic [7:0] obs);
    logic [7:0] exp_t;
    int n;
    exp_t = ref_table();
    n = 0;
    for (int v = 0; v < 8; v++) if (obs[v] != exp_t[v]) n++;
    return n;
  endfunction

  function automatic int model_first(input logic [7:0] obs);
    logic [7:0] exp_t;
    exp_t = ref_table();
    for (int v = 0; v < 8; v++) if (obs[v] != exp_t[v]) return v;
    return 0;
  endfunction

  // Pulses start and counts cycles (cycle 1 = first cycle after the start edge).
  task automatic run_sweep(input int repulse_at, output int lat, output logic busy1,
                           output logic busy_done, output logic done_next);
    int cyc;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    busy1 = busy;
    while (!done && cyc < 200) begin
      start = (cyc == repulse_at);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    lat = done ? cyc : -1;
    busy_done = busy;
    @(posedge clk); #1;
    done_next = done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (vec_out !== 3'd0) begin errors++; $display("FAIL reset_vec got=%0d exp=0", vec_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got=%b exp=0", pass); end
    checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL reset_err got=%0d exp=0", err_count); end
    checks++; if (first_fail !== 3'd0) begin errors++; $display("FAIL reset_first got=%0d exp=0", first_fail); end
    checks++; if (obs_table !== 8'h00) begin errors++; $display("FAIL reset_obs got=%h exp=00", obs_table); end
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_pass();
    int lat; logic b1, bd, dn;
    fut = ref_table();
    run_sweep(0, lat, b1, bd, dn);
    checks++; if (lat != 17) begin errors++; $display("FAIL pass_latency got=%0d exp=17", lat); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL pass_busy_rise got=%b exp=1", b1); end
    checks++; if (bd !== 1'b0) begin errors++; $display("FAIL pass_busy_finish got=%b exp=0", bd); end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL pass_done_pulse got=%b exp=0", dn); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL pass_pass got=%b exp=1", pass); end
    checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL pass_err got=%0d exp=0", err_count); end
`ifdef TT_SWEEP_OBS_EN
    checks++; if (obs_table !== 8'h31) begin errors++; $display("FAIL pass_obs got=%h exp=31", obs_table); end
`else
    checks++; if (obs_table !== 8'h00) begin errors++; $display("FAIL pass_obs got=%h exp=00", obs_table); end
`endif
  endtask

  task automatic test_stuck0();
    int lat; logic b1, bd, dn;
    fut = 8'h00;
    run_sweep(0, lat, b1, bd, dn);
    checks++; if (err_count !== 4'd3) begin errors++; $display("FAIL stuck0_err got=%0d exp=3", err_count); end
    checks++; if (first_fail !== 3'd0) begin errors++; $display("FAIL stuck0_first got=%0d exp=0", first_fail); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL stuck0_pass got=%b exp=0", pass); end
  endtask

  task automatic test_all_fail();
    int cyc;
    fut0 = ~ref_table();
    @(negedge clk) start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    cyc = 1;
    while (!done0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (!done0 || cyc != 9) begin errors++; $display("FAIL allfail_latency got=%0d exp=9", cyc); end
    checks++; if (err_count0 !== 4'd8) begin errors++; $display("FAIL allfail_err got=%0d exp=8", err_count0); end
    checks++; if (first_fail0 !== 3'd0) begin errors++; $display("FAIL allfail_first got=%0d exp=0", first_fail0); end
    checks++; if (pass0 !== 1'b0) begin errors++; $display("FAIL allfail_pass got=%b exp=0", pass0); end
  endtask

  task automatic test_random();
    int lat; logic b1, bd, dn;
    int e, f;
    for (int k = 0; k < 8; k++) begin
      fut = 8'($urandom);
      e = model_errs(fut);
      f = model_first(fut);
      run_sweep(0, lat, b1, bd, dn);
      checks++; if (lat != 17) begin errors++; $display("FAIL rand_latency[%0d] got=%0d exp=17", k, lat); end
      checks++; if (int'(err_count) != e) begin errors++; $display("FAIL rand_err[%0d] tbl=%h got=%0d exp=%0d", k, fut, err_count, e); end
      checks++; if (pass !== (e == 0)) begin errors++; $display("FAIL rand_pass[%0d] got=%b exp=%b", k, pass, e == 0); end
      if (e != 0) begin
        checks++; if (int'(first_fail) != f) begin errors++; $display("FAIL rand_first[%0d] tbl=%h got=%0d exp=%0d", k, fut, first_fail, f); end
      end
`ifdef TT_SWEEP_OBS_EN
      checks++; if (obs_table !== fut) begin errors++; $display("FAIL rand_obs[%0d] got=%h exp=%h", k, obs_table, fut); end
`endif
    end
  endtask

  task automatic test_start_ignored();
    int lat; logic b1, bd, dn;
    int dseen;
    fut = ref_table() ^ 8'h04;
    run_sweep(5, lat, b1, bd, dn);
    checks++; if (lat != 17) begin errors++; $display("FAIL restart_latency got=%0d exp=17", lat); end
    checks++; if (err_count !== 4'd1 || first_fail !== 3'd2) begin errors++; $display("FAIL restart_result got=%0d/%0d exp=1/2", err_count, first_fail); end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL restart_no_second got=%b exp=0", dn); end
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    dseen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (busy || done) dseen++;
    end
    checks++; if (dseen != 0) begin errors++; $display("FAIL start_abort_idle got=%0d busy/done cycles exp=0", dseen); end
  endtask

  task automatic test_abort();
    int lat; logic b1, bd, dn;
    int cyc, dseen;
    fut = ref_table();
    run_sweep(0, lat, b1, bd, dn);
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL abort_prior_pass got=%b exp=1", pass); end
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (vec_out != 3'd4 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (vec_out !== 3'd4) begin errors++; $display("FAIL abort_reach_vec4 got=%0d exp=4", vec_out); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL abort_pass got=%b exp=0", pass); end
    checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL abort_err got=%0d exp=0", err_count); end
    dseen = 0;
    repeat (25) begin
      if (done) dseen++;
      @(posedge clk); #1;
    end
    checks++; if (dseen != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", dseen); end
  endtask

  task automatic test_reset_mid();
    int lat; logic b1, bd, dn;
    int cyc;
    fut = ref_table() ^ 8'h40;
    run_sweep(0, lat, b1, bd, dn);
    checks++; if (err_count !== 4'd1 || first_fail !== 3'd6) begin errors++; $display("FAIL rstmid_prior got=%0d/%0d exp=1/6", err_count, first_fail); end
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (vec_out != 3'd5 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (vec_out !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0)
      begin errors++; $display("FAIL rstmid_ctrl got=v%0d b%b d%b p%b exp=v0 b0 d0 p0", vec_out, busy, done, pass); end
    checks++; if (err_count !== 4'd0 || first_fail !== 3'd0 || obs_table !== 8'h00)
      begin errors++; $display("FAIL rstmid_results got=%0d/%0d/%h exp=0/0/00", err_count, first_fail, obs_table); end
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_idle got=b%b d%b exp=b0 d0", busy, done); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_stuck0();
    test_all_fail();
    test_random();
    test_start_ignored();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
